// File: rtl/subcounter_dispatch_if.sv
// Request/response bundle between a requester and subcounter_dispatch.
// The requester (master) presents clear/increment/read/no-op commands with
// a valid/ready handshake and receives read data and the wrap pulse.
interface subcounter_dispatch_if #(
    parameter int GRANULARITY = 4,
    parameter int NUM_SUB     = 4
);
    logic                             cmd_valid;
    logic                             cmd_ready;
    logic [1:0]                       cmd_op;
    logic                             rd_valid;
    logic [GRANULARITY*NUM_SUB-1:0]   rd_data;
    logic                             ovf;

    modport master (
        output cmd_valid,
        output cmd_op,
        input  cmd_ready,
        input  rd_valid,
        input  rd_data,
        input  ovf
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        output cmd_ready,
        output rd_valid,
        output rd_data,
        output ovf
    );
endinterface

// File: rtl/subcounter_dispatch.sv
// Command front-end for a counter built from NUM_SUB chained subcounters.
// Turns clear/increment/read requests into per-lane 2-bit subcounter codes,
// walks the carry across lanes one lane per cycle, and captures the full
// counter value on reads.
//
// Build option: define SUBCOUNTER_LOOKAHEAD_EN to resolve the carry chain
// combinationally so an increment always completes in a single cycle.
//
// State table:
//   state | meaning
//   INIT  | reset; every lane cleared, no requests accepted
//   IDLE  | all lanes hold, ready for a request
//   CLR   | every lane cleared for one cycle
//   INC   | increment lane(s); ripple mode walks lane_idx upward on carry
//   RD    | lanes hold while the counter value is captured
module subcounter_dispatch #(
    parameter int GRANULARITY = 4,
    parameter int NUM_SUB     = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    subcounter_dispatch_if.slave           cmd_bus,
    output logic [2*NUM_SUB-1:0]           sub_command_out,
    input  logic [GRANULARITY*NUM_SUB-1:0] sub_data_in
);

    localparam int WIDTH = GRANULARITY * NUM_SUB;

    localparam logic [1:0] SC_CLEAR = 2'b00;
    localparam logic [1:0] SC_INC   = 2'b01;
    localparam logic [1:0] SC_HOLD  = 2'b10;

    localparam logic [1:0] OP_CLR = 2'b00;
    localparam logic [1:0] OP_INC = 2'b01;
    localparam logic [1:0] OP_RD  = 2'b10;

    localparam logic [2:0] ST_INIT = 3'd0;
    localparam logic [2:0] ST_IDLE = 3'd1;
    localparam logic [2:0] ST_CLR  = 3'd2;
    localparam logic [2:0] ST_INC  = 3'd3;
    localparam logic [2:0] ST_RD   = 3'd4;

    logic [2:0]         state;
    logic [2:0]         state_nxt;
    logic               accept;
    logic               wrap;
    logic [NUM_SUB-1:0] lane_ones;
    logic [NUM_SUB-1:0] lane_sel;

    logic               rd_valid_q;
    logic [WIDTH-1:0]   rd_data_q;
    logic               ovf_q;

`ifdef SUBCOUNTER_LOOKAHEAD_EN
    logic               all_ones;
    logic [NUM_SUB-1:0] inc_mask;
`else
    localparam int KW = (NUM_SUB > 1) ? $clog2(NUM_SUB) : 1;
    localparam logic [KW-1:0] LAST_LANE = KW'(NUM_SUB - 1);

    logic [KW-1:0] lane_idx;
    logic [KW-1:0] lane_idx_nxt;
    logic          cur_ones;
`endif

    assign accept            = cmd_bus.cmd_valid && (state == ST_IDLE);
    assign cmd_bus.cmd_ready = (state == ST_IDLE);
    assign cmd_bus.rd_valid  = rd_valid_q;
    assign cmd_bus.rd_data   = rd_data_q;
    assign cmd_bus.ovf       = ovf_q;

    // Flag each lane whose current value is all-ones (it will carry on increment).
    always_comb begin
        lane_ones = '0;
        for (int l = 0; l < NUM_SUB; l++) begin
            lane_ones[l] = &sub_data_in[l*GRANULARITY +: GRANULARITY];
        end
    end

`ifdef SUBCOUNTER_LOOKAHEAD_EN
    // Lane l increments when every lane below it is all-ones; lane 0 always does.
    always_comb begin
        logic prefix;
        prefix   = 1'b1;
        inc_mask = '0;
        for (int l = 0; l < NUM_SUB; l++) begin
            inc_mask[l] = prefix;
            prefix      = prefix & lane_ones[l];
        end
    end

    assign all_ones = &lane_ones;
    assign lane_sel = inc_mask;
    assign wrap     = (state == ST_INC) && all_ones;
`else
    assign cur_ones = lane_ones[lane_idx];
    assign wrap     = (state == ST_INC) && cur_ones && (lane_idx == LAST_LANE);

    // One-hot select of the lane currently being incremented in the ripple.
    always_comb begin
        lane_sel = '0;
        for (int l = 0; l < NUM_SUB; l++) begin
            lane_sel[l] = (lane_idx == KW'(l));
        end
    end
`endif

    // Next-state and carry-walk decisions.
    always_comb begin
        state_nxt = state;
`ifndef SUBCOUNTER_LOOKAHEAD_EN
        lane_idx_nxt = lane_idx;
`endif
        case (state)
            ST_INIT: state_nxt = ST_IDLE;
            ST_IDLE: begin
                if (accept) begin
                    case (cmd_bus.cmd_op)
                        OP_CLR: state_nxt = ST_CLR;
                        OP_INC: begin
                            state_nxt = ST_INC;
`ifndef SUBCOUNTER_LOOKAHEAD_EN
                            lane_idx_nxt = '0;
`endif
                        end
                        OP_RD:   state_nxt = ST_RD;
                        default: state_nxt = ST_IDLE;
                    endcase
                end
            end
            ST_CLR: state_nxt = ST_IDLE;
            ST_INC: begin
`ifdef SUBCOUNTER_LOOKAHEAD_EN
                state_nxt = ST_IDLE;
`else
                // The sampled value is pre-increment: all-ones means this lane
                // wraps at the coming edge and the next lane must take a carry.
                if (cur_ones && (lane_idx != LAST_LANE)) begin
                    lane_idx_nxt = lane_idx + 1'b1;
                end else begin
                    state_nxt = ST_IDLE;
                end
`endif
            end
            ST_RD:   state_nxt = ST_IDLE;
            default: state_nxt = ST_INIT;
        endcase
    end

    // Lane command codes; anything not explicitly commanded holds.
    always_comb begin
        sub_command_out = {NUM_SUB{SC_HOLD}};
        case (state)
            ST_INIT, ST_CLR: sub_command_out = {NUM_SUB{SC_CLEAR}};
            ST_INC: begin
                for (int l = 0; l < NUM_SUB; l++) begin
                    if (lane_sel[l]) begin
                        sub_command_out[2*l +: 2] = SC_INC;
                    end
                end
            end
            default: sub_command_out = {NUM_SUB{SC_HOLD}};
        endcase
    end

    // FSM state register; reset drops straight back to INIT, abandoning any ripple.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_INIT;
        end else begin
            state <= state_nxt;
        end
    end

`ifndef SUBCOUNTER_LOOKAHEAD_EN
    // Index of the lane receiving the increment during a ripple.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_idx <= '0;
        end else begin
            lane_idx <= lane_idx_nxt;
        end
    end
`endif

    // Registered read response and wrap pulse, both visible in the first IDLE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            ovf_q      <= 1'b0;
        end else begin
            rd_valid_q <= (state == ST_RD);
            ovf_q      <= wrap;
            if (state == ST_RD) begin
                rd_data_q <= sub_data_in;
            end
        end
    end

endmodule

// File: tb/tb_subcounter_dispatch.sv
// Bench for subcounter_dispatch: behavioural subcounters plus an integer
// model of the whole counter; randomized ops after directed scenarios.
module tb_subcounter_dispatch;

    localparam int G = 4;
    localparam int N = 4;
    localparam int W = G * N;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    subcounter_dispatch_if #(.GRANULARITY(G), .NUM_SUB(N)) cmd_bus ();

    logic [2*N-1:0] sub_cmd;
    logic [W-1:0]   lanes_q = 16'hA5C3;
    logic           pre_en  = 1'b0;
    logic [W-1:0]   pre_val = '0;

    subcounter_dispatch #(.GRANULARITY(G), .NUM_SUB(N)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cmd_bus         (cmd_bus),
        .sub_command_out (sub_cmd),
        .sub_data_in     (lanes_q)
    );

    // Behavioural subcounters (no reset); pre_en lets the bench load a value.
    always @(posedge clk) begin
        if (pre_en) begin
            lanes_q <= pre_val;
        end else begin
            for (int l = 0; l < N; l++) begin
                case (sub_cmd[2*l +: 2])
                    2'b00:   lanes_q[G*l +: G] <= '0;
                    2'b01:   lanes_q[G*l +: G] <= lanes_q[G*l +: G] + 1'b1;
                    default: ;
                endcase
            end
        end
    end

    int checks = 0;
    int failures = 0;
    int ovf_seen = 0;
    int rdv_seen = 0;
    int exp_ovf = 0;
    int exp_rdv = 0;
    logic [W-1:0] model_val = '0;
    logic [W-1:0] last_rd = '0;

    always @(negedge clk) begin
        if (cmd_bus.ovf === 1'b1) ovf_seen++;
        if (cmd_bus.rd_valid === 1'b1) rdv_seen++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [2*N-1:0] lane_word(input int lo, input int hi);
        logic [2*N-1:0] w;
        w = '0;
        for (int l = 0; l < N; l++) w[2*l +: 2] = (l >= lo && l <= hi) ? 2'b01 : 2'b10;
        return w;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 32'(cmd_bus.cmd_ready), 32'd0);
        check({tag, "_lanes"}, 32'(sub_cmd), 32'd0);
        check({tag, "_rdv"}, 32'(cmd_bus.rd_valid), 32'd0);
        check({tag, "_ovf"}, 32'(cmd_bus.ovf), 32'd0);
    endtask

    // Release reset just after an edge, check the INIT cycle, then IDLE.
    task automatic release_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("init_ready", 32'(cmd_bus.cmd_ready), 32'd0);
        check("init_lanes", 32'(sub_cmd), 32'd0);
        @(negedge clk);
        check("idle_ready", 32'(cmd_bus.cmd_ready), 32'd1);
        check("idle_lanes", 32'(sub_cmd), 32'(lane_word(N, N)));
        check("cleared", 32'(lanes_q), 32'd0);
        model_val = '0;
        last_rd = '0;
    endtask

    task automatic preload(input logic [W-1:0] v);
        pre_val = v;
        pre_en = 1'b1;
        @(negedge clk);
        pre_en = 1'b0;
        model_val = v;
    endtask

    // Issue one op (called at a negedge), hold it until accepted, then follow
    // the busy phase and compare against the counter model.
    task automatic run_op(input logic [1:0] op);
        int t;
        int exp_busy;
        int busy;
        int wait_n;
        logic exp_w;
        logic [W-1:0] nxt;
        logic [2*N-1:0] exp_lanes[8];
        logic [2*N-1:0] seen[8];

        t = 0;
        while (t < N && model_val[G*t +: G] == {G{1'b1}}) t++;
        exp_w = 1'b0;
        nxt = model_val;
        exp_busy = 0;
        for (int i = 0; i < 8; i++) begin
            exp_lanes[i] = '0;
            seen[i] = '0;
        end
        case (op)
            2'b00: begin exp_busy = 1; exp_lanes[0] = '0; nxt = '0; end
            2'b01: begin
`ifdef SUBCOUNTER_LOOKAHEAD_EN
                exp_busy = 1;
                exp_lanes[0] = lane_word(0, (t > N-1) ? N-1 : t);
`else
                exp_busy = 1 + ((t > N-1) ? N-1 : t);
                for (int i = 0; i < exp_busy; i++) exp_lanes[i] = lane_word(i, i);
`endif
                exp_w = (t == N);
                nxt = model_val + 1'b1;
            end
            2'b10: begin exp_busy = 1; exp_lanes[0] = lane_word(N, N); end
            default: exp_busy = 0;
        endcase

        cmd_bus.cmd_valid = 1'b1;
        cmd_bus.cmd_op = op;
        wait_n = 0;
        while (cmd_bus.cmd_ready !== 1'b1 && wait_n < 50) begin
            @(negedge clk);
            wait_n++;
        end
        check("accept_wait", 32'(wait_n < 50), 32'd1);
        @(negedge clk);
        busy = 0;
        while (cmd_bus.cmd_ready !== 1'b1 && busy < 8) begin
            seen[busy] = sub_cmd;
            busy++;
            @(negedge clk);
        end
        cmd_bus.cmd_valid = 1'b0;
        cmd_bus.cmd_op = 2'b11;

        check("busy_cycles", 32'(busy), 32'(exp_busy));
        for (int i = 0; i < busy && i < exp_busy; i++) check("lane_cmd", 32'(seen[i]), 32'(exp_lanes[i]));
        check("ovf_pulse", 32'(cmd_bus.ovf), 32'(exp_w));
        check("rd_valid", 32'(cmd_bus.rd_valid), 32'(op == 2'b10));
        if (op == 2'b10) begin
            check("rd_data", 32'(cmd_bus.rd_data), 32'(model_val));
            last_rd = model_val;
            exp_rdv++;
        end else begin
            check("rd_hold", 32'(cmd_bus.rd_data), 32'(last_rd));
        end
        if (exp_w) exp_ovf++;
        model_val = nxt;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        int ovf_before;
        logic [W-1:0] v;
        int nf;
        int r;

        cmd_bus.cmd_valid = 1'b0;
        cmd_bus.cmd_op = 2'b11;

        // Reset: 3 cycles low, then one INIT cycle.
        repeat (3) begin
            @(negedge clk);
            check_reset_outputs("rst");
        end
        check("rst_rd_data", 32'(cmd_bus.rd_data), 32'd0);
        release_reset();

        // Single increment from 0, then read; rd_valid lasts one cycle.
        run_op(2'b01);
        run_op(2'b10);
        check("single_rd", 32'(last_rd), 32'h0001);
        @(negedge clk);
        check("rdv_one_cycle", 32'(cmd_bus.rd_valid), 32'd0);
        check("rd_data_held", 32'(cmd_bus.rd_data), 32'h0001);

        // Carry ripple: 16 increments from 0 (back-to-back).
        run_op(2'b00);
        repeat (16) run_op(2'b01);
        run_op(2'b10);
        check("ripple_rd", 32'(last_rd), 32'h0010);

        // Full wrap.
        preload(16'hFFFF);
        run_op(2'b01);
        run_op(2'b10);
        check("wrap_rd", 32'(last_rd), 32'h0000);

        // Clear from a nonzero value.
        preload(16'h1234);
        run_op(2'b00);
        run_op(2'b10);
        check("clear_rd", 32'(last_rd), 32'h0000);

        // Two-lane carry (single cycle with lookahead).
        preload(16'h00FF);
        run_op(2'b01);
        run_op(2'b10);
        check("ff_rd", 32'(last_rd), 32'h0100);

`ifndef SUBCOUNTER_LOOKAHEAD_EN
        // Reset during INC(1) at 0x0FFF.
        preload(16'h0FFF);
        ovf_before = ovf_seen;
        cmd_bus.cmd_valid = 1'b1;
        cmd_bus.cmd_op = 2'b01;
        @(negedge clk);
        check("mid_lane0", 32'(sub_cmd), 32'(lane_word(0, 0)));
        @(negedge clk);
        check("mid_lane1", 32'(sub_cmd), 32'(lane_word(1, 1)));
        cmd_bus.cmd_valid = 1'b0;
        cmd_bus.cmd_op = 2'b11;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        repeat (2) @(negedge clk);
        release_reset();
        run_op(2'b10);
        check("mid_rd", 32'(last_rd), 32'h0000);
        check("mid_no_ovf", 32'(ovf_seen - ovf_before), 32'd0);
`endif

        // Randomized ops against the model.
        for (int it = 0; it < 250; it++) begin
            r = $urandom_range(0, 99);
            if (r < 8) begin
                v = W'($urandom);
                nf = $urandom_range(0, N);
                for (int l = 0; l < nf; l++) v[G*l +: G] = {G{1'b1}};
                preload(v);
            end else if (r < 70) begin
                run_op(2'b01);
            end else if (r < 82) begin
                run_op(2'b10);
            end else if (r < 88) begin
                run_op(2'b00);
            end else begin
                run_op(2'b11);
            end
        end
        run_op(2'b10);

        @(negedge clk);
        check("ovf_total", 32'(ovf_seen), 32'(exp_ovf));
        check("rdv_total", 32'(rdv_seen), 32'(exp_rdv));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/subcounter_dispatch.md
# subcounter_dispatch

Command front-end for one shared counter built from a chain of `subcounter` instances. It accepts clear/increment/read requests over a valid/ready handshake and turns them into per-lane 2-bit `sub_command_in` codes. It sequences carry propagation across lanes by watching each subcounter's `data_out`, and returns the concatenated counter value on reads. It sits directly upstream of the `NUM_SUB` subcounters and drives their command inputs.

## Interface
- `GRANULARITY`, default 4: width of each subcounter (bits per lane).
- `NUM_SUB`, default 4, minimum 2: number of chained subcounters. Lane 0 is least significant.

Ports:
- `clk`  in  1: single clock; all state changes on the rising edge.
- `rst_n`  in  1: reset, asynchronous assert, active-low.
- `cmd_valid`  in  1: request present.
- `cmd_ready`  out  1: block can accept a request this cycle.
- `cmd_op`  in  2: `00` clear, `01` increment, `10` read, `11` no-op.
- `sub_command_out`  out  2*NUM_SUB: lane k occupies bits [2k+1:2k] and drives subcounter k.
  - `00` clear, `01` increment, `10` hold; `11` is never driven.
- `sub_data_in`  in  GRANULARITY*NUM_SUB: lane k is subcounter k's `data_out`.
- `rd_valid`  out  1: one-cycle pulse; `rd_data` is valid.
- `rd_data`  out  GRANULARITY*NUM_SUB: captured counter value.
- `ovf`  out  1: one-cycle pulse when the full counter wraps from all-ones to zero.

## Operation
- A request is accepted on a rising edge where `cmd_valid && cmd_ready`. `cmd_ready` is high only in IDLE.
- `sub_command_out` is combinational from state and lane index. Every lane not explicitly commanded drives `10` (hold).
- Subcounters have no reset, so this block clears them.

FSM states:
- **INIT**: reset state.
  - All lanes `00`, `cmd_ready`=0.
  - Stays in INIT while `rst_n` is low; goes to IDLE on the first edge after release.
- **IDLE**: all lanes `10`, `cmd_ready`=1.
  - Accepted op `00` → CLR; `01` → INC with k=0; `10` → RD; `11` → stay in IDLE.
- **CLR**: all lanes `00` for one cycle → IDLE.
- **INC(k)**: lane k drives `01`.
  - Sample lane k of `sub_data_in`. This is the pre-increment value; the subcounter updates at the edge that ends this cycle.
  - If it is not all-ones → IDLE.
  - If it is all-ones and k<NUM_SUB-1 → INC(k+1).
  - If it is all-ones and k=NUM_SUB-1 → IDLE, and `ovf` is registered high for the next cycle.
- **RD**: all lanes `10`.
  - At the edge ending the cycle: `rd_data` <= `sub_data_in` and `rd_valid` <= 1 → IDLE.
  - `rd_valid` is high exactly one cycle, the first IDLE cycle. `rd_data` holds its value until the next read.
- Arithmetic is modulo 2^(GRANULARITY*NUM_SUB). Wrap-around asserts `ovf` and leaves every lane at 0.
- A request arriving while busy is not accepted. The requester must hold `cmd_valid` and `cmd_op` stable until accepted.
- `rst_n` low in any state (including mid-ripple) forces INIT immediately:
  - The ripple is abandoned; `rd_valid` and `ovf` drop to 0.
  - Lanes drive `00`, so the counter restarts at 0.

## Timing
- Reset values: `cmd_ready`=0, `sub_command_out` = all `00`, `rd_valid`=0, `rd_data`=0, `ovf`=0.
- After `rst_n` rises, INIT lasts until the next edge. `cmd_ready` rises one cycle after reset release.
- Clear: 1 busy cycle. `cmd_ready` returns the cycle after the clear cycle.
- Increment: 1+m busy cycles, where m is the number of low lanes that were all-ones, capped at NUM_SUB-1.
  - Lanes receive `01` in ascending order, one lane per cycle.
- Read: 1 busy cycle. `rd_valid` coincides with the returning `cmd_ready`, so a new request is accepted in that same cycle.
- Back-to-back: a request accepted in the first IDLE cycle after completion sees fully settled lanes.

## Configuration
- `SUBCOUNTER_LOOKAHEAD_EN` defined: INC completes in a single cycle.
  - Lanes 0..j drive `01`, where j is the lowest lane whose current value is not all-ones.
  - If every lane is all-ones, all lanes drive `01` and `ovf` pulses the next cycle.
  - Busy time is always 1 cycle.
- Undefined: ripple behaviour as specified above.

## Test plan
The bench instantiates NUM_SUB behavioural subcounters (GRANULARITY=4, NUM_SUB=4), with codes 00 clear, 01 increment, 10 hold.
- **Reset**: hold `rst_n` low 3 cycles → all lanes `00`, `cmd_ready`=0, `rd_valid`=0, `ovf`=0. After release: one INIT cycle, then `cmd_ready`=1 with all lanes `10`.
- **Single increment**: one increment from 0 → lane 0 = `01` for exactly 1 cycle. A following read pulses `rd_valid` with `rd_data`=0x0001.
- **Carry ripple**: 16 increments → the 16th is busy 2 cycles (lane 0 then lane 1); read = 0x0010.
  - While busy, `cmd_valid` held high is not accepted until `cmd_ready` returns.
- **Full wrap**: 65535 increments then one more → 4 busy cycles with lanes 0,1,2,3 commanded in order. `ovf` pulses 1 cycle; read = 0x0000.
- **Reset mid-ripple / clear**:
  - At 0x0FFF, issue an increment and assert `rst_n` low during INC(1) → after release, read = 0x0000 and `ovf` never pulsed.
  - Separately, clear at 0x1234 → read = 0x0000.
- **With `SUBCOUNTER_LOOKAHEAD_EN`**: increment at 0x00FF → one busy cycle with lanes 0,1,2 = `01` and lane 3 = `10`; read = 0x0100.
